query_scheduler: RTL and testbench

Arbitrates the three appliance query requests (cumulative use time, power-on time, cleaning reminder) plus exit into a single active display selection, and returns the display to idle after a programmable timeout. Sits between the debounced button layer and the seven-segment display mux, replacing ad-hoc flag setting with one FSM that owns which query is shown.

---
 rtl/query_pkg.sv | 30 +++
 rtl/query_timer.sv | 36 +++
 rtl/query_scheduler.sv | 90 +++++++++
 tb/tb_query_scheduler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/query_pkg.sv
// Shared types for the query scheduler: FSM state encoding and one-hot display selects.
package query_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHOW_USE = 2'd1,
        SHOW_ON  = 2'd2,
        SHOW_REM = 2'd3
    } query_state_e;

    // Select bit order is {reminder, on, use}.
    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_USE  = 3'b001;
    localparam logic [2:0] SEL_ON   = 3'b010;
    localparam logic [2:0] SEL_REM  = 3'b100;

    function automatic logic [2:0] state_sel(input query_state_e st);
        logic [2:0] s;
        s = SEL_NONE;
        unique case (st)
            IDLE:     s = SEL_NONE;
            SHOW_USE: s = SEL_USE;
            SHOW_ON:  s = SEL_ON;
            SHOW_REM: s = SEL_REM;
            default:  s = SEL_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/query_timer.sv
// Display timeout counter: counts while enabled, clear has priority, flags the last count.
module query_timer #(
    parameter int unsigned Cycles = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned Width = $clog2(Cycles);
    localparam logic [Width-1:0] Last = Width'(Cycles - 1);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == Last);

endmodule

// File: rtl/query_scheduler.sv
// Picks which appliance query the display shows; optional auto-expiry when
// QUERY_TIMEOUT_EN is defined, otherwise queries stay up until exit/request/power-off.
module query_scheduler
    import query_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_status,
    input  logic       req_use,
    input  logic       req_on,
    input  logic       req_reminder,
    input  logic       exit_req,
    output logic [2:0] sel,
    output logic       active,
    output logic       timeout_pulse
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("query_scheduler: TIMEOUT_CYCLES must be at least 2");
    end

    query_state_e state_q, state_d;
    logic [2:0]   sel_q, sel_d;
    logic         active_q;
    logic         pulse_q, pulse_d;
    logic         expire;

`ifdef QUERY_TIMEOUT_EN
    logic timer_en;
    logic timer_clr;

    // Any accepted input or leaving SHOW restarts the count from zero.
    assign timer_en  = (state_q != IDLE);
    assign timer_clr = !power_status | req_use | req_on | req_reminder | exit_req
                       | expire | !timer_en;

    query_timer #(
        .Cycles (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clr_i    (timer_clr),
        .en_i     (timer_en),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        if (!power_status) begin
            state_d = IDLE;
        end else if (req_reminder) begin
            state_d = SHOW_REM;
        end else if (req_on) begin
            state_d = SHOW_ON;
        end else if (req_use) begin
            state_d = SHOW_USE;
        end else if (exit_req) begin
            state_d = IDLE;
        end else if (expire) begin
            state_d = IDLE;
            pulse_d = 1'b1;
        end
        sel_d = state_sel(state_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sel_q    <= SEL_NONE;
            active_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            active_q <= |sel_d;
            pulse_q  <= pulse_d;
        end
    end

    assign sel           = sel_q;
    assign active        = active_q;
    assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_query_scheduler.sv
// Scoreboard bench for query_scheduler; expectations adapt to QUERY_TIMEOUT_EN.
module tb_query_scheduler;

    localparam int unsigned T = 8;
`ifdef QUERY_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int HOLD = TO_EN ? 3 : 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       power_status;
    logic       req_use;
    logic       req_on;
    logic       req_reminder;
    logic       exit_req;
    logic [2:0] sel;
    logic       active;
    logic       timeout_pulse;

    string      name_q[$];
    logic [4:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    query_scheduler #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .power_status  (power_status),
        .req_use       (req_use),
        .req_on        (req_on),
        .req_reminder  (req_reminder),
        .exit_req      (exit_req),
        .sel           (sel),
        .active        (active),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got sel=%b active=%b pulse=%b, expected sel=%b active=%b pulse=%b",
                     name, got[4:2], got[1], got[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // One clock of stimulus; expected outputs are those visible after the next rising edge.
    task automatic step(input string name, input logic p, input logic ru, input logic ro,
                        input logic rr, input logic ex, input logic [2:0] es, input logic ep);
        @(negedge clk);
        power_status = p;
        req_use      = ru;
        req_on       = ro;
        req_reminder = rr;
        exit_req     = ex;
        name_q.push_back(name);
        exp_q.push_back({es, |es, ep});
    endtask

    initial begin : monitor
        forever begin
            string      nm;
            logic [4:0] e;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                nm = name_q.pop_front();
                e  = exp_q.pop_front();
                check(nm, {sel, active, timeout_pulse}, e);
            end
        end
    end

    initial begin : stimulus
        rst          = 1'b0;
        power_status = 1'b1;
        req_use      = 1'b0;
        req_on       = 1'b0;
        req_reminder = 1'b0;
        exit_req     = 1'b0;
        #1;
        check("reset_state", {sel, active, timeout_pulse}, 5'b000_0_0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        step("idle", 1, 0, 0, 0, 0, 3'b000, 0);
        step("exit_in_idle", 1, 0, 0, 0, 1, 3'b000, 0);

        // req_on then silence: expires after exactly T cycles when the timer exists
        step("req_on", 1, 0, 1, 0, 0, 3'b010, 0);
        for (int k = 1; k <= int'(T); k++) begin
            if (TO_EN && k == int'(T)) step("on_expire", 1, 0, 0, 0, 0, 3'b000, 1);
            else                       step("on_hold", 1, 0, 0, 0, 0, 3'b010, 0);
        end
        step("exit_after_on", 1, 0, 0, 0, 1, 3'b000, 0);
        step("idle_no_pulse", 1, 0, 0, 0, 0, 3'b000, 0);

        // Priority
        step("use_and_rem", 1, 1, 0, 1, 0, 3'b100, 0);
        step("exit_rem", 1, 0, 0, 0, 1, 3'b000, 0);
        step("idle_after_exit", 1, 0, 0, 0, 0, 3'b000, 0);
        step("on_and_use", 1, 1, 1, 0, 0, 3'b010, 0);
        step("all_four", 1, 1, 1, 1, 1, 3'b100, 0);
        step("use_and_exit", 1, 1, 0, 0, 1, 3'b001, 0);
        step("exit_use", 1, 0, 0, 0, 1, 3'b000, 0);

        // Re-request restarts the timer
        step("req_use", 1, 1, 0, 0, 0, 3'b001, 0);
        for (int k = 1; k <= 4; k++) step("use_hold_a", 1, 0, 0, 0, 0, 3'b001, 0);
        step("use_restart", 1, 1, 0, 0, 0, 3'b001, 0);
        for (int k = 1; k <= int'(T); k++) begin
            if (TO_EN && k == int'(T)) step("use_expire", 1, 0, 0, 0, 0, 3'b000, 1);
            else                       step("use_hold_b", 1, 0, 0, 0, 0, 3'b001, 0);
        end

        // Request on the expiry cycle wins without a pulse
        step("req_use_2", 1, 1, 0, 0, 0, 3'b001, 0);
        for (int k = 1; k < int'(T); k++) step("use_hold_c", 1, 0, 0, 0, 0, 3'b001, 0);
        step("on_at_expiry", 1, 0, 1, 0, 0, 3'b010, 0);
        step("on_after_race", 1, 0, 0, 0, 0, 3'b010, 0);

        // Power loss
        step("req_rem", 1, 0, 0, 1, 0, 3'b100, 0);
        step("power_drop", 0, 0, 0, 0, 0, 3'b000, 0);
        step("use_power_off", 0, 1, 0, 0, 0, 3'b000, 0);
        step("rem_power_off", 0, 0, 0, 1, 0, 3'b000, 0);
        step("power_back", 1, 0, 0, 0, 0, 3'b000, 0);

        // Long hold, then asynchronous reset mid-display
        step("req_on_2", 1, 0, 1, 0, 0, 3'b010, 0);
        for (int k = 0; k < HOLD; k++) step("on_long_hold", 1, 0, 0, 0, 0, 3'b010, 0);
        @(negedge clk);
        power_status = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset", {sel, active, timeout_pulse}, 5'b000_0_0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step("after_reset", 1, 0, 0, 0, 0, 3'b000, 0);
        step("req_on_3", 1, 0, 1, 0, 0, 3'b010, 0);
        step("exit_on", 1, 0, 0, 0, 1, 3'b000, 0);

        @(negedge clk);
        exit_req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
